fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch stage with a small prefetch FIFO, sitting directly upstream of the IF/ID pipeline register. It generates the fetch PC and reads instructions from the combinational instruction memory into a DEPTH-entry queue. It presents the head entry, as instruction plus PC, to the IF/ID register. A `bubble` output drives that register's `empty` input whenever no valid instruction is available. Taken branches and jumps flush the queue and redirect the PC.

## Interface
- `ADDR_W`, 32, PC/address width
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `RESET_PC`, 0, fetch PC after reset
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `imem_addr`  out  ADDR_W  current fetch PC
- `imem_rdata`  in  DATA_W  instruction at `imem_addr`, valid combinationally in the same cycle
- `redirect`  in  1  taken branch/jump resolved downstream
- `redirect_pc`  in  ADDR_W  target PC, sampled when `redirect`=1
- `deq`  in  1  IF/ID register write enable; consumes the head entry
- `inst_out`  out  DATA_W  head instruction; 0 when empty
- `pc_out`  out  ADDR_W  head PC; 0 when empty
- `bubble`  out  1  1 when no valid head; connects to IF/ID `empty`
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: `fetch_pc`, circular storage of {pc, inst} pairs, `rd_ptr`, `wr_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH), and `count`.
- `imem_addr` = `fetch_pc`.
- Push when `redirect`=0 and (`count`<DEPTH or `pop`=1). A push stores {`fetch_pc`, `imem_rdata`} at `wr_ptr` and sets `fetch_pc` += 4 (wraps modulo 2^ADDR_W).
- Pop when `redirect`=0, `deq`=1 and `count`>0. A pop advances `rd_ptr`.
- `deq` with `count`=0 is ignored. In that case `bubble`=1, so IF/ID loads zeros.
- Simultaneous push and pop:
  - `count` is unchanged.
  - This is legal when full: the slot freed by the pop is refilled in the same edge.
- `redirect`=1 has top priority:
  - `count`←0 and `rd_ptr`←`wr_ptr`←0.
  - `fetch_pc`←`redirect_pc`.
  - No push and no pop in that cycle, regardless of `deq`.
- Full with no pop: `fetch_pc` holds, and `imem_addr` stays on the next unfetched PC.
- `bubble` = (`count`==0). `inst_out`/`pc_out` come from the `rd_ptr` entry when `count`>0, otherwise they are 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - `fetch_pc`=RESET_PC, pointers 0, `count`=0.
  - Outputs: `bubble`=1, `inst_out`=0, `pc_out`=0, `imem_addr`=RESET_PC.
  - Storage contents need not be cleared.
- Reset release is synchronous to the next posedge. The first push happens on the first edge with `rst`=1.
- Fetch-to-output latency is 1 cycle: an entry pushed at edge N is visible on `inst_out` after edge N.
- Redirect at edge N:
  - `imem_addr`=`redirect_pc` after N.
  - First push at N+1; target visible at outputs after N+1.
  - `bubble`=1 between N and N+1.
- Reset asserted mid-operation discards all queued entries immediately.
- All outputs are registered-state derived except through the configurable bypass. No combinational path from `deq` to outputs.

## Configuration
- `FETCH_BUF_BYPASS_EN` defined: when `count`==0 and `redirect`=0, `inst_out`=`imem_rdata`, `pc_out`=`fetch_pc` and `bubble`=0.
  - If `deq`=1 in that cycle, the instruction is consumed directly: `fetch_pc` += 4, nothing is stored, `count` stays 0.
  - Fetch-to-output latency is 0 when empty.
  - Adds a combinational path from `imem_rdata` to `inst_out`.
- Not defined: behaviour exactly as in Operation/Timing.

## Test plan
- Reset then fill: `rst` low 2 cycles, release, `deq`=0 for 6 cycles.
  - Expected: `count` goes 1,2,3,4,4,4; `imem_addr` holds at RESET_PC+16; `pc_out`=RESET_PC; `bubble`=0 from the first edge.
- Streaming: `deq`=1 every cycle after the first push, imem returns `addr ^ 32'hA5A5_0000`.
  - Expected: `pc_out` sequence 0,4,8,…; `count` steady at 1; `inst_out` matches its PC.
- Redirect while full: `count`=4, `redirect`=1, `redirect_pc`=32'h100, `deq`=1.
  - Expected next cycle: `count`=0, `bubble`=1, `imem_addr`=32'h100.
  - Expected following cycle: `pc_out`=32'h100.
- Full with simultaneous push/pop: `count`=4, `deq`=1.
  - Expected: `count` stays 4, pop order preserved across pointer wrap (head PCs 0,4,8,12,16,20).
- Underflow and mid-run reset:
  - `deq`=1 while empty: `count` stays 0, `bubble`=1, outputs 0.
  - Assert `rst`=0 between edges with `count`=3: `count`=0 and `imem_addr`=RESET_PC immediately, without a clock edge.
- Bypass (`FETCH_BUF_BYPASS_EN` defined): first cycle after reset, `imem_rdata`=32'h0000_0013, `deq`=1.
  - Expected: `bubble`=0, `inst_out`=32'h13 in the same cycle; after the edge `count`=0 and `imem_addr`=RESET_PC+4.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: instruction memory port, redirect input and the head
// entry presented to the IF/ID register.
interface fetch_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              deq;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] pc_out;
    logic              bubble;
    logic [CNT_W-1:0]  count;

    modport master (
        output imem_addr, inst_out, pc_out, bubble, count,
        input  imem_rdata, redirect, redirect_pc, deq
    );

    modport slave (
        input  imem_addr, inst_out, pc_out, bubble, count,
        output imem_rdata, redirect, redirect_pc, deq
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch stage with a DEPTH-entry prefetch FIFO feeding IF/ID.
// Optional macro FETCH_BUF_BYPASS_EN forwards imem_rdata straight out when empty.
module fetch_buffer #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_show;
    logic bypass_take;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

`ifdef FETCH_BUF_BYPASS_EN
    // When empty, the memory word is offered directly; a deq consumes it unstored.
    assign bypass_show = empty && !bus.redirect;
    assign bypass_take = bypass_show && bus.deq;
`else
    assign bypass_show = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign pop  = !bus.redirect && bus.deq && !empty;
    assign push = !bus.redirect && !bypass_take && (!full || pop);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        if (bus.redirect) begin
            fetch_pc_next = bus.redirect_pc;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (push || bypass_take) begin
                fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
            inst_mem[wr_ptr_reg] <= bus.imem_rdata;
        end
    end

    always_comb begin
        bus.bubble   = empty;
        bus.inst_out = '0;
        bus.pc_out   = '0;
        if (!empty) begin
            bus.inst_out = inst_mem[rd_ptr_reg];
            bus.pc_out   = pc_mem[rd_ptr_reg];
        end else if (bypass_show) begin
            bus.inst_out = bus.imem_rdata;
            bus.pc_out   = fetch_pc_reg;
            bus.bubble   = 1'b0;
        end
    end

    assign bus.imem_addr = fetch_pc_reg;
    assign bus.count     = count_reg;
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: queue-based reference model checked every
// cycle, plus literal expectations for reset, fill, wrap, redirect and underflow.
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] key;
    int          total = 0;
    int          bad   = 0;

    ent_t        mq[$];
    logic [31:0] mpc = RESET_PC;
    int          exp_fill[6] = '{1, 2, 3, 4, 4, 4};

    fetch_buffer_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();

    // Instruction memory: each word is a keyed function of its address.
    assign bus.imem_rdata = bus.imem_addr ^ key;

    fetch_buffer #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of {pc, inst} with the redirect/push/pop rules.
    always @(posedge clk or negedge rst) begin
        bit popped;
        bit room;
        if (!rst) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (bus.redirect) begin
            mq.delete();
            mpc = bus.redirect_pc;
        end else if (BYP && mq.size() == 0 && bus.deq) begin
            mpc = mpc + 32'd4;
        end else begin
            popped = bus.deq && (mq.size() > 0);
            room   = mq.size() < DEPTH;
            if (popped) void'(mq.pop_front());
            if (room || popped) begin
                mq.push_back('{mpc, mpc ^ key});
                mpc = mpc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_inst, e_pc;
        logic        e_bub;
        e_inst = 32'h0;
        e_pc   = 32'h0;
        e_bub  = 1'b1;
        if (mq.size() > 0) begin
            e_inst = mq[0].inst;
            e_pc   = mq[0].pc;
            e_bub  = 1'b0;
        end else if (BYP && !bus.redirect) begin
            e_inst = mpc ^ key;
            e_pc   = mpc;
            e_bub  = 1'b0;
        end
        check("model_count", 32'(bus.count), 32'(mq.size()));
        check("model_imem_addr", bus.imem_addr, mpc);
        check("model_bubble", 32'(bus.bubble), 32'(e_bub));
        check("model_inst_out", bus.inst_out, e_inst);
        check("model_pc_out", bus.pc_out, e_pc);
    end

    initial begin
        rst             = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.deq         = 1'b0;
        key             = 32'hA5A5_0000;
`ifdef FETCH_BUF_BYPASS_EN
        key = 32'h13;
`endif
        step();
        step();
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_imem_addr", bus.imem_addr, RESET_PC);
`ifndef FETCH_BUF_BYPASS_EN
        check("reset_bubble", 32'(bus.bubble), 32'd1);
        check("reset_inst_out", bus.inst_out, 32'h0);
        check("reset_pc_out", bus.pc_out, 32'h0);
`else
        rst     = 1'b1;
        bus.deq = 1'b1;
        #1;
        check("byp_bubble", 32'(bus.bubble), 32'd0);
        check("byp_inst_out", bus.inst_out, 32'h13);
        check("byp_pc_out", bus.pc_out, RESET_PC);
        step();
        check("byp_count", 32'(bus.count), 32'd0);
        check("byp_imem_addr", bus.imem_addr, RESET_PC + 32'd4);
        rst     = 1'b0;
        bus.deq = 1'b0;
        step();
        step();
        key = 32'hA5A5_0000;
`endif
        // Fill from reset with no dequeue
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("fill_count", 32'(bus.count), 32'(exp_fill[i]));
        end
        check("fill_imem_addr", bus.imem_addr, RESET_PC + 32'd16);
        check("fill_pc_out", bus.pc_out, RESET_PC);
        check("fill_bubble", 32'(bus.bubble), 32'd0);
        check("fill_inst_out", bus.inst_out, RESET_PC ^ 32'hA5A5_0000);

        // Full with simultaneous push and pop, across pointer wrap
        bus.deq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("wrap_pc_out", bus.pc_out, 32'(4 * i));
            check("wrap_count", 32'(bus.count), 32'd4);
            step();
        end

        // Redirect while full
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        bus.deq      = 1'b0;
        check("redir_count", 32'(bus.count), 32'd0);
        check("redir_imem_addr", bus.imem_addr, 32'h100);
`ifndef FETCH_BUF_BYPASS_EN
        check("redir_bubble", 32'(bus.bubble), 32'd1);
`endif
        step();
        check("redir_pc_out", bus.pc_out, 32'h100);
        check("redir_count2", 32'(bus.count), 32'd1);

        // Streaming from PC 0
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect = 1'b0;
        step();
        bus.deq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("stream_pc_out", bus.pc_out, 32'(4 * i));
            check("stream_inst_out", bus.inst_out, 32'(4 * i) ^ 32'hA5A5_0000);
            check("stream_count", 32'(bus.count), 32'd1);
            step();
        end

        // Underflow: deq while empty
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        step();
        check("under_count", 32'(bus.count), 32'd0);
        check("under_bubble", 32'(bus.bubble), 32'd1);
        check("under_inst_out", bus.inst_out, 32'h0);
        check("under_pc_out", bus.pc_out, 32'h0);
        bus.redirect = 1'b0;
        #1;
`ifndef FETCH_BUF_BYPASS_EN
        check("under_bubble2", 32'(bus.bubble), 32'd1);
        step();
        check("under_count2", 32'(bus.count), 32'd1);
        check("under_pc_out2", bus.pc_out, 32'h200);
`else
        check("under_byp_pc_out", bus.pc_out, 32'h200);
        step();
        check("under_byp_count", 32'(bus.count), 32'd0);
        check("under_byp_imem_addr", bus.imem_addr, 32'h204);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.deq         = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = $urandom;
            if ($urandom_range(0, 31) == 0) key = $urandom;
            step();
        end

        // Mid-run asynchronous reset with three entries queued
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        bus.deq         = 1'b0;
        step();
        bus.redirect = 1'b0;
        step();
        step();
        step();
        check("mid_count_before", 32'(bus.count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("mid_count", 32'(bus.count), 32'd0);
        check("mid_imem_addr", bus.imem_addr, RESET_PC);
`ifndef FETCH_BUF_BYPASS_EN
        check("mid_bubble", 32'(bus.bubble), 32'd1);
`endif
        step();
        step();
        rst = 1'b1;
        step();
        check("post_reset_count", 32'(bus.count), 32'd1);
        check("post_reset_pc_out", bus.pc_out, RESET_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
